demux_rr_scheduler: RTL and testbench
=====================================

Name: demux_rr_scheduler

Overview:
- Stream controller that drives a 1-to-4 demux: accepts words on a single valid/ready input and delivers each to exactly one of four output channels.
- Target channel per word comes from round-robin rotation (mode=0) or an explicit destination field (mode=1).
- Holds one word in a registered stage; broadcasts data on a shared bus with a one-hot per-channel valid, in the demux style.
- Sits between a single producer and four consumer lanes.

Parameters:
- DATA_W, 8, width of data word
- CNT_W, 8, width of per-channel transfer counters (used only with DEMUX_CNT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  scheduler can accept a word this cycle
- in_data  input  DATA_W  input word
- in_dest  input  2  destination channel, used when mode=1
- mode  input  1  0 = round-robin, 1 = directed
- out_data  output  DATA_W  held word, shared by all channels
- out_valid  output  4  one-hot valid, bit i = channel i
- out_ready  input  4  per-channel consumer ready
- sel  output  2  current target channel (demux select)
- busy  output  1  high while a word is held
- xfer_cnt  output  4*CNT_W  per-channel counters, channel i at [i*CNT_W +: CNT_W]; present only with DEMUX_CNT_EN

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, sel=0, busy=0, rr_ptr=0, xfer_cnt=0.
  - in_ready is combinational and therefore 1 after reset.
- FSM states: IDLE, HOLD.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid: load in_data into the hold register.
  - Target = in_dest if mode=1, else rr_ptr. Register the target into sel.
  - Go to HOLD.
- HOLD:
  - out_valid = onehot(sel), busy=1.
  - A transfer completes when out_ready[sel]=1. out_ready bits for other channels are ignored.
- in_ready in HOLD = out_ready[sel] (combinational pass-through):
  - Completion with in_valid=1: load the next word and new target in the same cycle, stay in HOLD. This gives full throughput: one word per cycle when the target is ready.
  - Completion with in_valid=0: go to IDLE, out_valid=0 next cycle.
- Latency: word accepted at edge N appears on out_data/out_valid after edge N (visible in cycle N+1). Minimum input-to-output latency is 1 cycle.
- Round-robin pointer:
  - Sampled at accept; advances by 1 at each accept made in mode=0 (3 wraps to 0).
  - Unchanged by directed-mode accepts.
  - Strict rotation: no skipping of channels that are not ready. The held word waits indefinitely for its target.
- Mode and in_dest are sampled only at accept. Changing them while a word is held has no effect on that word.
- in_data and in_dest are ignored when in_valid=0.
- Stability: out_data, sel and out_valid remain stable while out_valid is asserted and not accepted.
- Reset mid-operation: the held word is discarded with no completion, rr_ptr returns to 0, counters clear.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Four CNT_W-bit counters, one per channel.
  - Counter i increments on each completed transfer to channel i.
  - Counters saturate at all-ones and do not wrap.
  - Exported on xfer_cnt.
- Undefined: no counters, no xfer_cnt port. All other behaviour is identical.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4 and CH_W=2.
  - State encoding (IDLE=1'b0, HOLD=1'b1).
  - Mode encoding (MODE_RR=0, MODE_DIR=1).
  - onehot4 function mapping 2-bit select to 4-bit one-hot.
- One sub-module: demux_sat_counter (CNT_W-bit saturating counter, inc and clear inputs), instantiated four times under DEMUX_CNT_EN.

Test Plan:
- RR back-to-back: reset; mode=0, out_ready=4'b1111, in_valid held with data 0xA0..0xA5 -> out_valid sequence 0001, 0010, 0100, 1000, 0001, 0010; one word per cycle; in_ready always 1.
- Directed with backpressure: mode=1, dest=2, data=0x5C, out_ready=4'b1011 for 3 cycles, then 4'b0100 -> out_valid=0100 held 4 cycles; out_data stays 0x5C; in_ready=0 until bit 2 rises; ready on other channels ignored.
- Mode mix: RR accepts 0x11 (ch0), directed accepts 0x22 (dest 3), RR accepts 0x33 -> 0x33 goes to ch1; directed accept leaves rr_ptr unchanged.
- Idle gap: single word 0x7E with out_ready=4'b1111 -> out_valid asserted one cycle, then IDLE; busy returns to 0; no spurious out_valid.
- Reset mid-HOLD: word 0x99 held at ch1 with out_ready=0, assert rst asynchronously mid-cycle -> out_valid=0 and busy=0 immediately; next RR word goes to ch0.
- DEMUX_CNT_EN with CNT_W=2: 5 transfers to ch0 -> xfer_cnt[ch0]=3 (saturated); other counters 0; macro undefined -> design compiles without the xfer_cnt port.

Source files
------------

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-4 demux round-robin scheduler.
//   NUM_CH / CH_W : channel count and select width
//   state_t       : scheduler FSM states (IDLE = empty, HOLD = word held)
//   mode_t        : target selection mode (round-robin or directed)
//   onehot4()     : 2-bit select to 4-bit one-hot channel valid
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic {
        MODE_RR  = 1'b0,
        MODE_DIR = 1'b1
    } mode_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] s);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_sat_counter.sv
// ---------------------------------------------------------------------------
// demux_sat_counter
// CNT_W-bit up counter that sticks at all-ones instead of wrapping.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the count
//   inc  : add one this cycle (ignored once saturated)
//   clr  : synchronous clear, takes priority over inc
//   cnt  : current count
// ---------------------------------------------------------------------------
module demux_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// demux_rr_scheduler
// Single valid/ready producer feeding four consumer lanes through a 1-to-4
// demux. One word is held in a register stage; its data is broadcast on
// out_data and exactly one bit of out_valid marks the target lane. The target
// is taken from a rotating round-robin pointer (mode=0) or from in_dest
// (mode=1), sampled when the word is accepted.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_valid/ready  : producer handshake; in_ready is combinational
//   in_data/in_dest : word and its directed destination
//   mode            : 0 = round-robin, 1 = directed
//   out_data        : held word, shared by all lanes
//   out_valid       : one-hot lane valid
//   out_ready       : per-lane ready; only the targeted lane's bit matters
//   sel             : demux select (target of the held word)
//   busy            : a word is held
//   xfer_cnt        : per-lane saturating completion counters, present only
//                     when DEMUX_CNT_EN is defined (lane i at [i*CNT_W +: CNT_W])
// ---------------------------------------------------------------------------
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_dest,
    input  logic              mode,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [CH_W-1:0]   sel,
    output logic              busy
`ifdef DEMUX_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
`endif
);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [CH_W-1:0]     sel_reg, sel_next;
    logic [CH_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                accept;
    logic                complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            sel_reg    <= sel_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        sel_next    = sel_reg;
        rr_ptr_next = rr_ptr_reg;

        // In HOLD the slot frees up exactly when the targeted lane takes the
        // word, so a new word can be loaded on that same edge.
        complete = (state_reg == HOLD) && out_ready[sel_reg];
        in_ready = (state_reg == IDLE) ? 1'b1 : out_ready[sel_reg];
        accept   = in_valid && in_ready;

        if (accept) begin
            data_next  = in_data;
            state_next = HOLD;
            if (mode_t'(mode) == MODE_DIR) begin
                sel_next = in_dest;
            end else begin
                sel_next    = rr_ptr_reg;
                rr_ptr_next = rr_ptr_reg + 1'b1;   // 3 wraps to 0
            end
        end else if (complete) begin
            state_next = IDLE;
        end
    end

    assign out_data  = data_reg;
    assign sel       = sel_reg;
    assign busy      = (state_reg == HOLD);
    assign out_valid = (state_reg == HOLD) ? onehot4(sel_reg) : '0;

`ifdef DEMUX_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            demux_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (complete && (sel_reg == CH_W'(gi))),
                .clr (1'b0),
                .cnt (xfer_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_scheduler
// Scoreboard bench: the stimulus side predicts the lane of every accepted
// word and queues it; a monitor compares whatever the DUT presents against
// the head of that queue and retires it when the targeted lane is ready.
// Optional counter checks are compiled in with DEMUX_CNT_EN.
// ---------------------------------------------------------------------------
module tb_demux_rr_scheduler;

    localparam int TB_CNT_W = 2;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       mode;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] sel;
    logic       busy;
`ifdef DEMUX_CNT_EN
    logic [4*TB_CNT_W-1:0] xfer_cnt;
`endif

    exp_t q[$];
    int   rr_model;
    int   cnt_model[4];
    int   total;
    int   bad;

    demux_rr_scheduler #(
        .DATA_W (8)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W  (TB_CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_model();
        q.delete();
        rr_model = 0;
        for (int i = 0; i < 4; i++) cnt_model[i] = 0;
    endtask

    // One cycle of stimulus: drive at the falling edge, then (after the
    // monitor has looked at this cycle) record any handshake that will be
    // taken at the coming rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] dst,
                         input logic m, input logic [3:0] rdy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        mode      = m;
        out_ready = rdy;
        #3;
        if (in_valid && in_ready) begin
            e.data = in_data;
            if (m) begin
                e.ch = dst;
            end else begin
                e.ch     = 2'(rr_model);
                rr_model = (rr_model + 1) % 4;
            end
            q.push_back(e);
            $display("accept data=0x%02h mode=%0d lane=%0d", e.data, m, e.ch);
        end
    endtask

    // Asynchronous reset asserted in the middle of the high phase.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(out_valid), 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        chk("rst_async_in_ready", 32'(in_ready), 32'h1);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares what the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("busy", 32'(busy), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_valid", 32'(out_valid), 32'(4'b0001 << q[0].ch));
                chk("out_data", 32'(out_data), 32'(q[0].data));
                chk("sel", 32'(sel), 32'(q[0].ch));
                chk("in_ready_hold", 32'(in_ready), 32'(out_ready[q[0].ch]));
                if (out_ready[q[0].ch]) begin
                    $display("deliver data=0x%02h lane=%0d", q[0].data, q[0].ch);
                    if (cnt_model[q[0].ch] < (1 << TB_CNT_W) - 1)
                        cnt_model[q[0].ch]++;
                    void'(q.pop_front());
                end
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'h0);
                chk("in_ready_idle", 32'(in_ready), 32'h1);
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        mode      = 1'b0;
        out_ready = '0;
        clear_model();

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        // Round-robin back-to-back, all lanes ready.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hA0 + 8'(i), 2'd0, 1'b0, 4'b1111);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

        // Directed word to lane 2 under backpressure; other lanes' ready ignored.
        cycle(1'b1, 8'h5C, 2'd2, 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 2'd1, 1'b0, 4'b1011);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b0100);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b0100);

        // Mode mix from a fresh round-robin pointer.
        mid_reset();
        cycle(1'b1, 8'h11, 2'd0, 1'b0, 4'b1111);
        cycle(1'b1, 8'h22, 2'd3, 1'b1, 4'b1111);
        cycle(1'b1, 8'h33, 2'd0, 1'b0, 4'b1111);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

        // Single word followed by an idle gap.
        cycle(1'b1, 8'h7E, 2'd0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'hFF, 2'd3, 1'b1, 4'b1111);

        // Reset while a word is held on lane 1; next RR word goes to lane 0.
        mid_reset();
        cycle(1'b1, 8'h98, 2'd0, 1'b0, 4'b1111);
        cycle(1'b1, 8'h99, 2'd0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
        mid_reset();
        cycle(1'b1, 8'h55, 2'd2, 1'b0, 4'b1111);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom),
                  1'($urandom), 4'($urandom));
        end

        // Drain and confirm nothing was lost or duplicated.
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
        chk("drain_queue_empty", 32'(q.size()), 32'h0);

`ifdef DEMUX_CNT_EN
        chk("cnt_ch0", 32'(xfer_cnt[0*TB_CNT_W +: TB_CNT_W]), 32'(cnt_model[0]));
        chk("cnt_ch1", 32'(xfer_cnt[1*TB_CNT_W +: TB_CNT_W]), 32'(cnt_model[1]));
        chk("cnt_ch2", 32'(xfer_cnt[2*TB_CNT_W +: TB_CNT_W]), 32'(cnt_model[2]));
        chk("cnt_ch3", 32'(xfer_cnt[3*TB_CNT_W +: TB_CNT_W]), 32'(cnt_model[3]));
        // Five directed transfers to lane 0 from a cleared state saturate it.
        mid_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 2'd0, 1'b1, 4'b1111);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
        chk("cnt_sat_ch0", 32'(xfer_cnt[0 +: TB_CNT_W]), 32'h3);
        chk("cnt_sat_others", 32'(xfer_cnt[4*TB_CNT_W-1:TB_CNT_W]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
